// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

  localparam int DIVIDEND_W_DEF = 16;
  localparam int DIVISOR_W_DEF  = 8;
  localparam int CNT_W_DEF      = $clog2(DIVIDEND_W_DEF);

  typedef enum logic {
    IDLE,
    WORK
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 qbit_o
);

  logic [DIVISOR_W:0] shifted;
  logic               unused_msb;

  // The incoming msb is always shifted out, so only the low bits feed the step.
  assign unused_msb = rem_i[DIVISOR_W];

  always_comb begin
    shifted = {rem_i[DIVISOR_W-1:0], bit_i};
    qbit_o  = (shifted >= {1'b0, divisor_i});
    rem_o   = qbit_o ? (shifted - {1'b0, divisor_i}) : shifted;
  end

endmodule

// File: rtl/div.sv
// Sequential restoring divider: one quotient bit per clock, start/busy handshake.
module div
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DIVIDEND_W-1:0] a_bi,
  input  logic [DIVISOR_W-1:0]  b_bi,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic [DIVIDEND_W-1:0] q_bo,
  output logic [DIVISOR_W-1:0]  r_bo,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(DIVIDEND_W);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  r_q, r_d;
  logic                  err_q, err_d;

  logic [DIVISOR_W:0]    stepRem;
  logic                  stepQ;
  logic [DIVIDEND_W-1:0] quoNext;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_i     (rem_q),
    .bit_i     (dvd_q[DIVIDEND_W-1]),
    .divisor_i (dvs_q),
    .rem_o     (stepRem),
    .qbit_o    (stepQ)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      q_q     <= q_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  // Visible results only move on the completing edge; start requests in WORK are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    q_d     = q_q;
    r_d     = r_q;
    err_d   = err_q;
    quoNext = {quo_q[DIVIDEND_W-2:0], stepQ};

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = WORK;
          dvd_d   = a_bi;
          dvs_d   = b_bi;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_W'(DIVIDEND_W - 1);
        end
      end
      WORK: begin
        dvd_d = {dvd_q[DIVIDEND_W-2:0], 1'b0};
        rem_d = stepRem;
        quo_d = quoNext;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = IDLE;
          q_d     = quoNext;
          r_d     = stepRem[DIVISOR_W-1:0];
          err_d   = (dvs_q == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q == WORK);
  assign q_bo   = q_q;
  assign r_bo   = r_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_div.sv
// Directed, table-driven self-checking bench for the sequential divider.
module tb_div;

  logic        clk_i   = 1'b0;
  logic        rst_i   = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] a_bi    = '0;
  logic [7:0]  b_bi    = '0;
  logic        busy_o;
  logic [15:0] q_bo;
  logic [7:0]  r_bo;
  logic        err_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        err;
  } vec_t;

  vec_t vecs [7];

  div dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_bi    (a_bi),
    .b_bi    (b_bi),
    .start_i (start_i),
    .busy_o  (busy_o),
    .q_bo    (q_bo),
    .r_bo    (r_bo),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Launch one operation from an idle negedge and count busy cycles; optionally
  // fires a second start mid-operation and scrambles the operand inputs.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b, input int pulseAt,
                               input logic [15:0] holdQ, output int busyCycles);
    a_bi    = a;
    b_bi    = b;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i    = 1'b0;
    busyCycles = 0;
    while (busy_o && busyCycles < 40) begin
      busyCycles++;
      if (busyCycles == 8) checkOutput("holdQ", 32'(q_bo), 32'(holdQ));
      if (pulseAt != 0 && busyCycles == pulseAt) begin
        start_i = 1'b1;
        a_bi    = 16'd9;
        b_bi    = 8'd3;
      end else if (pulseAt != 0 && busyCycles == pulseAt + 1) begin
        start_i = 1'b0;
        a_bi    = 16'hABCD;
        b_bi    = 8'h55;
      end
      @(negedge clk_i);
    end
  endtask

  initial begin
    int          cyc;
    int          idle;
    logic [15:0] prevQ;

    vecs[0] = '{a: 16'd1872,  b: 8'd117, q: 16'd16,    r: 8'd0,  err: 1'b0};
    vecs[1] = '{a: 16'd1000,  b: 8'd7,   q: 16'd142,   r: 8'd6,  err: 1'b0};
    vecs[2] = '{a: 16'd65535, b: 8'd1,   q: 16'd65535, r: 8'd0,  err: 1'b0};
    vecs[3] = '{a: 16'd65025, b: 8'd255, q: 16'd255,   r: 8'd0,  err: 1'b0};
    vecs[4] = '{a: 16'd10,    b: 8'd20,  q: 16'd0,     r: 8'd10, err: 1'b0};
    vecs[5] = '{a: 16'd5,     b: 8'd0,   q: 16'hFFFF,  r: 8'd5,  err: 1'b1};
    vecs[6] = '{a: 16'd100,   b: 8'd9,   q: 16'd11,    r: 8'd1,  err: 1'b0};

    #3 rst_i = 1'b0;
    #1;
    checkOutput("rstBusy", 32'(busy_o), 32'd0);
    checkOutput("rstQ",    32'(q_bo),   32'd0);
    checkOutput("rstR",    32'(r_bo),   32'd0);
    checkOutput("rstErr",  32'(err_o),  32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("relBusy", 32'(busy_o), 32'd0);
    checkOutput("relQ",    32'(q_bo),   32'd0);

    prevQ = '0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, 0, prevQ, cyc);
      checkOutput("busyLen", 32'(cyc),   32'd16);
      checkOutput("quot",    32'(q_bo),  32'(vecs[i].q));
      checkOutput("rem",     32'(r_bo),  32'(vecs[i].r));
      checkOutput("err",     32'(err_o), 32'(vecs[i].err));
      if (vecs[i].b != 8'd0) begin
        checkOutput("invariant", 32'(int'(q_bo) * int'(vecs[i].b) + int'(r_bo)), 32'(vecs[i].a));
        checkOutput("remLtDiv",  32'(r_bo < vecs[i].b), 32'd1);
      end
      prevQ = vecs[i].q;
    end

    applyStimulus(16'd300, 8'd7, 4, prevQ, cyc);
    checkOutput("ignBusyLen", 32'(cyc),   32'd16);
    checkOutput("ignQuot",    32'(q_bo),  32'd42);
    checkOutput("ignRem",     32'(r_bo),  32'd6);
    checkOutput("ignErr",     32'(err_o), 32'd0);
    @(negedge clk_i);
    checkOutput("ignNoQueue", 32'(busy_o), 32'd0);

    a_bi    = 16'd200;
    b_bi    = 8'd3;
    start_i = 1'b1;
    @(negedge clk_i);
    cyc = 0;
    while (busy_o && cyc < 40) begin
      cyc++;
      if (cyc == 8) checkOutput("heldHold1", 32'(q_bo), 32'd42);
      @(negedge clk_i);
    end
    checkOutput("heldLen1", 32'(cyc),  32'd16);
    checkOutput("heldQ1",   32'(q_bo), 32'd66);
    checkOutput("heldR1",   32'(r_bo), 32'd2);
    a_bi = 16'd255;
    b_bi = 8'd16;
    idle = 0;
    while (!busy_o && idle < 5) begin
      idle++;
      @(negedge clk_i);
    end
    checkOutput("heldIdle", 32'(idle), 32'd1);
    cyc = 0;
    while (busy_o && cyc < 40) begin
      cyc++;
      if (cyc == 2) start_i = 1'b0;
      if (cyc == 8) checkOutput("heldHold2", 32'(q_bo), 32'd66);
      @(negedge clk_i);
    end
    checkOutput("heldLen2", 32'(cyc),  32'd16);
    checkOutput("heldQ2",   32'(q_bo), 32'd15);
    checkOutput("heldR2",   32'(r_bo), 32'd15);
    @(negedge clk_i);
    checkOutput("heldStop", 32'(busy_o), 32'd0);

    a_bi    = 16'd1872;
    b_bi    = 8'd117;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (7) @(negedge clk_i);
    checkOutput("midBusy", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    checkOutput("abortBusy", 32'(busy_o), 32'd0);
    checkOutput("abortQ",    32'(q_bo),   32'd0);
    checkOutput("abortR",    32'(r_bo),   32'd0);
    checkOutput("abortErr",  32'(err_o),  32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (20) @(negedge clk_i);
    checkOutput("abortNoRun", 32'(busy_o), 32'd0);
    checkOutput("abortNoQ",   32'(q_bo),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Sequential restoring integer divider; the inverse operation of the team's shift-add multiplier.
- Uses the same start/busy handshake, so the same control logic can drive either unit.
- Computes quotient and remainder of a DIVIDEND_W-bit unsigned dividend by a DIVISOR_W-bit unsigned divisor, one quotient bit per clock.

Parameters:
- DIVIDEND_W, 16, width of dividend and quotient
- DIVISOR_W, 8, width of divisor and remainder

Ports:
- clk_i  input  1  clock; all state changes on rising edge
- rst_i  input  1  reset; asynchronous, active-low
- a_bi  input  DIVIDEND_W  dividend, unsigned
- b_bi  input  DIVISOR_W  divisor, unsigned
- start_i  input  1  request; sampled on rising edge when idle
- busy_o  output  1  high while a division is in progress
- q_bo  output  DIVIDEND_W  quotient of last completed operation
- r_bo  output  DIVISOR_W  remainder of last completed operation
- err_o  output  1  last completed operation had divisor zero

Behaviour:
- Reset (rst_i low, async): state IDLE; busy_o=0, q_bo=0, r_bo=0, err_o=0; counter and working registers cleared. A reset mid-operation aborts the operation with no result update.
- States: IDLE, WORK.
- IDLE -> WORK:
  - Transition on a rising edge with start_i=1.
  - On that edge: latch a_bi into the dividend shift register, b_bi into the divisor register, clear the partial remainder (DIVISOR_W+1 bits), set the counter to DIVIDEND_W-1, set busy_o=1.
- WORK, each cycle:
  - rem' = {rem[DIVISOR_W-1:0], dividend msb}; shift dividend left.
  - If rem' >= {0,divisor}: rem = rem' - divisor and quotient bit = 1. Otherwise rem = rem' and quotient bit = 0.
  - Shift the quotient bit into the quotient register LSB.
  - Counter decrements.
- Completion:
  - On the edge that processes counter==0: q_bo and r_bo load the final values, err_o = (divisor==0), busy_o=0, state returns to IDLE.
  - Total busy_o high time is exactly DIVIDEND_W cycles (16 with defaults). Results are valid on the edge where busy_o falls.
- Divide by zero:
  - No special path. The algorithm runs its full latency and yields q_bo = all ones and r_bo = a[DIVISOR_W-1:0].
  - err_o=1.
- Outputs q_bo, r_bo and err_o hold their values until the next completion. They do not change at start or during WORK.
- start_i while busy_o=1 is ignored. Operands are not re-sampled, and the request is not queued.
- start_i held high continuously: a new operation begins on the first edge after return to IDLE, i.e. one idle cycle between operations.
- a_bi and b_bi may change freely after the start edge; only latched copies are used.
- Invariant, checked by the bench on every completion with b != 0: q_bo*b + r_bo == a, and r_bo < b.

Decomposition:
- Shared package:
  - DIVIDEND_W/DIVISOR_W defaults, shared with the multiplier package constants.
  - State enum {IDLE, WORK}.
  - Counter width constant, clog2(DIVIDEND_W).
- One natural combinational sub-module, div_step: inputs partial remainder, incoming dividend bit and divisor; outputs next remainder and quotient bit. It is reusable for an unrolled or pipelined variant later.
- The FSM, counter and registers stay in div.

Test Plan:
- Reset low for 1 cycle, release -> busy_o=0, q_bo=0, r_bo=0, err_o=0. Reset asserted at cycle 8 of a running operation -> busy_o=0 immediately (async), outputs 0, no completion.
- a=1872, b=117, 1-cycle start pulse -> busy_o high for exactly 16 cycles, then q_bo=16, r_bo=0, err_o=0. Also a=1000, b=7 -> q_bo=142, r_bo=6.
- a=65535, b=1 -> q_bo=65535, r_bo=0. a=65025, b=255 -> q_bo=255, r_bo=0. a=10, b=20 -> q_bo=0, r_bo=10.
- a=5, b=0 -> after 16 cycles q_bo=16'hFFFF, r_bo=5, err_o=1. The following op a=100, b=9 -> q_bo=11, r_bo=1, err_o=0.
- Start a=300, b=7, then at busy cycle 4 pulse start_i with a=9, b=3 and change a_bi/b_bi -> result q_bo=42, r_bo=6; second request ignored; busy_o falls at cycle 16.
- start_i held high across two ops (a=200, b=3 then a=255, b=16) -> results q=66/r=2 then q=15/r=15; exactly one idle cycle between busy periods; q_bo unchanged during the second WORK until its completion.
